// File: rtl/slc3_mem_io_responder.sv
// rtl/slc3_mem_io_responder.sv - SLC-3 memory/IO responder with on-chip RAM, switch/hex I/O and wait-state ready
// Optional LED register at IO_ADDR-1 enabled by defining SLC3_LED_REG_EN.
module slc3_mem_io_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    input  logic [9:0]  SW,
    output logic [15:0] HEX_reg
`ifdef SLC3_LED_REG_EN
    ,
    output logic [9:0]  LED_reg
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0]  LP_CNT_INIT = 4'(WAIT_STATES - 1);
    localparam logic [19:0] LP_LED_ADDR = IO_ADDR - 20'd1;

    state_t r_state;
    state_t w_next_state;
    logic   w_r;

    logic [3:0]  r_cnt;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_ub_n;
    logic        r_lb_n;
    logic        r_is_write;

    logic [15:0] r_mem [0:(2**ADDR_BITS)-1];
    logic [15:0] r_ram_q;
    logic [15:0] r_rd_hold;
    logic [15:0] r_hex;

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_is_io;
    logic                 w_is_led;
    logic                 w_ram_sel;
    logic [ADDR_BITS-1:0] w_idx;
    logic [15:0]          w_rd_value;

`ifdef SLC3_LED_REG_EN
    logic [9:0] r_led;
    assign LED_reg  = r_led;
    assign w_is_led = (r_addr == LP_LED_ADDR);
`else
    assign w_is_led = 1'b0;
`endif

    // A new access is only taken from IDLE; both strobes low counts as a write.
    assign w_accept  = (r_state == S_IDLE) && !CE && (!OE || !WE);
    assign w_is_io   = (r_addr == IO_ADDR);
    assign w_ram_sel = !w_is_io && !w_is_led;
    assign w_idx     = r_addr[ADDR_BITS-1:0];
    // Writes land on the clock edge that ends ACK; a reset on that edge cancels them.
    assign w_commit  = (r_state == S_ACK) && r_is_write && !Reset;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode; CE rising during WAIT aborts the access.
    always_comb begin
        w_next_state = r_state;
        w_r          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (CE) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_r          = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign R = w_r;

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= LP_CNT_INIT;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Bus capture at acceptance; later bus activity is ignored until the next access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr     <= 20'h00000;
            r_wdata    <= 16'h0000;
            r_ub_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= ADDR;
            r_wdata    <= Data_from_CPU;
            r_ub_n     <= UB;
            r_lb_n     <= LB;
            r_is_write <= !WE;
        end
    end

    // Single-port word RAM with byte writes and registered read of the latched address.
    always_ff @(posedge Clk) begin
        if (w_commit && w_ram_sel) begin
            if (!r_ub_n) begin
                r_mem[w_idx][15:8] <= r_wdata[15:8];
            end
            if (!r_lb_n) begin
                r_mem[w_idx][7:0] <= r_wdata[7:0];
            end
        end
        r_ram_q <= r_mem[w_idx];
    end

    // Hex display register written through the I/O address with byte enables.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hex <= 16'h0000;
        end else if (w_commit && w_is_io) begin
            if (!r_ub_n) begin
                r_hex[15:8] <= r_wdata[15:8];
            end
            if (!r_lb_n) begin
                r_hex[7:0] <= r_wdata[7:0];
            end
        end
    end

    assign HEX_reg = r_hex;

`ifdef SLC3_LED_REG_EN
    // LED register takes the low ten data bits regardless of byte enables.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_led <= 10'h000;
        end else if (w_commit && w_is_led) begin
            r_led <= r_wdata[9:0];
        end
    end
`endif

    // Read source select; switches are sampled live during ACK.
    always_comb begin
        w_rd_value = r_ram_q;
        if (w_is_io) begin
            w_rd_value = {6'b0, SW};
        end
`ifdef SLC3_LED_REG_EN
        if (w_is_led) begin
            w_rd_value = {6'b0, r_led};
        end
`endif
    end

    // Holds the last read result so Data_to_CPU is stable between reads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_hold <= 16'h0000;
        end else if ((r_state == S_ACK) && !r_is_write) begin
            r_rd_hold <= w_rd_value;
        end
    end

    assign Data_to_CPU = ((r_state == S_ACK) && !r_is_write) ? w_rd_value : r_rd_hold;

endmodule

// File: tb/tb_slc3_mem_io_responder.sv
// tb/tb_slc3_mem_io_responder.sv - randomized model-checked bench for slc3_mem_io_responder
module tb_slc3_mem_io_responder;

    localparam int          WS      = 2;
    localparam int          AB      = 10;
    localparam logic [19:0] IO_A    = 20'h0FFFF;
    localparam logic [19:0] LED_A   = 20'h0FFFE;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        R;
    logic [9:0]  SW;
    logic [15:0] HEX_reg;
`ifdef SLC3_LED_REG_EN
    logic [9:0]  LED_reg;
`endif

    slc3_mem_io_responder #(.ADDR_BITS(AB), .WAIT_STATES(WS), .IO_ADDR(IO_A)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU),
        .R(R), .SW(SW), .HEX_reg(HEX_reg)
`ifdef SLC3_LED_REG_EN
        , .LED_reg(LED_reg)
`endif
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int accept_cyc = 0;
    int r_cyc   = 0;
    int r_pulses = 0;
    logic [15:0] seen_ack_data = 16'h0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [15:0] m_ram [0:(2**AB)-1];
    logic [15:0] m_hex;
    logic [9:0]  m_led;
    logic [15:0] last_rd;
    logic        exp_r;
    logic [15:0] exp_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Single compare process: every cycle, DUT outputs against the model's expectations
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("R", {31'b0, R}, {31'b0, exp_r});
            chk("Data_to_CPU", {16'b0, Data_to_CPU}, {16'b0, exp_dout});
            chk("HEX_reg", {16'b0, HEX_reg}, {16'b0, m_hex});
`ifdef SLC3_LED_REG_EN
            chk("LED_reg", {22'b0, LED_reg}, {22'b0, m_led});
`endif
            if (R === 1'b1) begin
                r_pulses++;
                r_cyc = cyc;
                seen_ack_data = Data_to_CPU;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic release_bus();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
    endtask

    function automatic logic [15:0] model_read(input logic [19:0] a);
        if (a == IO_A) return {6'b0, SW};
`ifdef SLC3_LED_REG_EN
        if (a == LED_A) return {6'b0, m_led};
`endif
        return m_ram[a[AB-1:0]];
    endfunction

    task automatic model_write(input logic [19:0] a, input logic [15:0] d,
                               input logic ub_n, input logic lb_n);
        logic [15:0] w;
        if (a == IO_A) begin
            if (!ub_n) m_hex[15:8] = d[15:8];
            if (!lb_n) m_hex[7:0]  = d[7:0];
            return;
        end
`ifdef SLC3_LED_REG_EN
        if (a == LED_A) begin
            m_led = d[9:0];
            return;
        end
`endif
        w = m_ram[a[AB-1:0]];
        if (!ub_n) w[15:8] = d[15:8];
        if (!lb_n) w[7:0]  = d[7:0];
        m_ram[a[AB-1:0]] = w;
    endtask

    // One bus access; abort_at/reset_at pick a WAIT cycle (1..WS) to abort or reset in, 0 = none
    task automatic access(input bit wr, input logic [19:0] a, input logic [15:0] d,
                          input logic ub_n, input logic lb_n, input bit both,
                          input int abort_at, input int reset_at);
        CE = 1'b0; ADDR = a; Data_from_CPU = d; UB = ub_n; LB = lb_n;
        if (wr) begin WE = 1'b0; OE = both ? 1'b0 : 1'b1; end
        else    begin WE = 1'b1; OE = 1'b0; end
        step();
        accept_cyc = cyc;
        for (int c = 1; c <= WS; c++) begin
            ADDR = 20'($urandom); Data_from_CPU = 16'($urandom);
            UB = 1'($urandom); LB = 1'($urandom); OE = 1'($urandom); WE = 1'($urandom);
            if (c == abort_at) begin
                CE = 1'b1;
                step();
                release_bus();
                return;
            end
            if (c == reset_at) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                release_bus();
                m_hex = 16'h0; m_led = 10'h0; last_rd = 16'h0; exp_dout = 16'h0;
                return;
            end
            step();
        end
        release_bus();
        exp_r = 1'b1;
        if (!wr) begin
            last_rd  = model_read(a);
            exp_dout = last_rd;
        end
        step();
        exp_r = 1'b0;
        exp_dout = last_rd;
        if (wr) model_write(a, d, ub_n, lb_n);
    endtask

    int p0;

    initial begin
        Reset = 1'b1; SW = 10'h000; ADDR = 20'h0; Data_from_CPU = 16'h0;
        release_bus();
        m_hex = 16'h0; m_led = 10'h0; last_rd = 16'h0;
        exp_r = 1'b0; exp_dout = 16'h0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_R", {31'b0, R}, 32'h0);
        chk("reset_data", {16'b0, Data_to_CPU}, 32'h0);
        chk("reset_hex", {16'b0, HEX_reg}, 32'h0);

        // Fill RAM so every later read has defined content
        for (int i = 0; i < 2**AB; i++) begin
            access(1'b1, 20'(i), 16'($urandom), 1'b0, 1'b0, 1'b0, 0, 0);
        end

        // Write then read with latency check
        access(1'b1, 20'h00005, 16'hBEEF, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("write_latency", r_cyc - accept_cyc + 1, WS + 1);
        access(1'b0, 20'h00005, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("read_latency", r_cyc - accept_cyc + 1, 3);
        chk("read_beef", {16'b0, seen_ack_data}, 32'h0000BEEF);

        // Switch read and hex write; aliased RAM word behind IO_ADDR stays untouched
        access(1'b1, 20'h003FF, 16'h3FF0, 1'b0, 1'b0, 1'b0, 0, 0);
        SW = 10'h2A5;
        step();
        access(1'b0, IO_A, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("sw_read", {16'b0, seen_ack_data}, 32'h000002A5);
        access(1'b1, IO_A, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("hex_write", {16'b0, HEX_reg}, 32'h00001234);
        access(1'b0, 20'h003FF, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("ram_3ff_kept", {16'b0, seen_ack_data}, 32'h00003FF0);

        // Byte enables
        access(1'b1, 20'h00010, 16'hAAAA, 1'b0, 1'b0, 1'b0, 0, 0);
        access(1'b1, 20'h00010, 16'h5555, 1'b1, 1'b0, 1'b0, 0, 0);
        access(1'b0, 20'h00010, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("byte_lo", {16'b0, seen_ack_data}, 32'h0000AA55);
        access(1'b1, 20'h00010, 16'h1111, 1'b0, 1'b1, 1'b1, 0, 0);
        access(1'b0, 20'h00010, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("byte_hi", {16'b0, seen_ack_data}, 32'h00001155);

        // Address aliasing
        access(1'b1, 20'h00400, 16'h0777, 1'b0, 1'b0, 1'b0, 0, 0);
        access(1'b0, 20'h00000, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("alias", {16'b0, seen_ack_data}, 32'h00000777);

        // Abort during WAIT
        access(1'b1, 20'h00020, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 0);
        p0 = r_pulses;
        access(1'b1, 20'h00020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1, 0);
        step();
        chk("abort_no_r", r_pulses - p0, 0);
        access(1'b0, 20'h00020, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("abort_read", {16'b0, seen_ack_data}, 32'h00000001);

        // Reset during WAIT of a hex write and of a RAM write
        p0 = r_pulses;
        access(1'b1, IO_A, 16'hCAFE, 1'b0, 1'b0, 1'b0, 0, WS);
        access(1'b1, 20'h00020, 16'h2222, 1'b0, 1'b0, 1'b0, 0, 1);
        step();
        chk("reset_no_r", r_pulses - p0, 0);
        chk("reset_hex_zero", {16'b0, HEX_reg}, 32'h0);
        access(1'b0, 20'h00020, 16'h0, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("reset_read", {16'b0, seen_ack_data}, 32'h00000001);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int k, sel, ab, rs;
            logic [19:0] a;
            bit wr;
            k  = $urandom_range(0, 99);
            wr = 1'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = IO_A;
            else if (sel == 1) a = LED_A;
            else if (sel == 2) a = 20'h003FF;
            else               a = 20'($urandom_range(0, 31)) | (20'($urandom_range(0, 3)) << AB);
            ab = (k < 10) ? $urandom_range(1, WS) : 0;
            rs = (k >= 10 && k < 13) ? $urandom_range(1, WS) : 0;
            access(wr, a, 16'($urandom), 1'($urandom), 1'($urandom),
                   wr & 1'($urandom), ab, rs);
            if ($urandom_range(0, 3) == 0) SW = 10'($urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slc3_mem_io_responder.md
Name: slc3_mem_io_responder

Overview:
- Memory-side responder for the SLC-3 CPU bus: answers CPU read/write strobes from on-chip word RAM.
- Memory-mapped I/O at 0xFFFF: reads return board switches (SW), writes update the hex-display register.
- Sits between slc3 core and board pins inside slc3_testtop, replacing the external SRAM path.
- Gives the CPU an explicit ready (R) after a programmable wait-state count.

Parameters:
- ADDR_BITS, 10, RAM depth = 2**ADDR_BITS 16-bit words.
- WAIT_STATES, 2, cycles from access acceptance to R pulse; legal 1..15.
- IO_ADDR, 20'h0FFFF, switch/hex I/O address (full 20-bit compare).

Ports:
- Clk  in  1  system clock, 50 MHz, rising edge.
- Reset  in  1  synchronous, active-high.
- CE  in  1  chip enable, active-low.
- UB  in  1  upper byte enable, active-low (writes only).
- LB  in  1  lower byte enable, active-low (writes only).
- OE  in  1  output enable / read strobe, active-low.
- WE  in  1  write enable, active-low.
- ADDR  in  20  word address from CPU MAR.
- Data_from_CPU  in  16  write data.
- Data_to_CPU  out  16  read data.
- R  out  1  ready, one-cycle pulse at access completion.
- SW  in  10  board switches.
- HEX_reg  out  16  value shown on HEX3..HEX0.

Behaviour:
- Reset: state IDLE, R=0, Data_to_CPU=16'h0000, HEX_reg=16'h0000, wait counter 0. RAM contents not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE -> WAIT on cycle with CE=0 and (OE=0 or WE=0). Latch ADDR, Data_from_CPU, UB, LB, op type. Counter loads WAIT_STATES-1.
- OE=0 and WE=0 together: treated as write.
- WAIT: counter decrements each cycle; at 0 -> ACK. With WAIT_STATES=1, WAIT lasts one cycle.
- ACK (one cycle): R=1.
  - Read: Data_to_CPU updated this cycle.
  - Write: RAM/IO commit on the ACK clock edge.
- ACK exit: IDLE next cycle, R=0. Back-to-back: new access cannot be accepted earlier than the cycle after ACK.
- Total latency, acceptance edge to R high: WAIT_STATES+1 cycles.
- Abort: CE goes high during WAIT -> return to IDLE, no R pulse, no write, Data_to_CPU unchanged.
- Bus changes during WAIT are ignored; latched values are used.
- Read data:
  - RAM word at ADDR[ADDR_BITS-1:0]; higher non-IO address bits ignored (aliasing/wrap).
  - At IO_ADDR: {6'b0, SW} sampled in ACK cycle.
  - Data_to_CPU holds last read value until the next read ACK or Reset.
- Writes:
  - UB=0 writes [15:8]; LB=0 writes [7:0].
  - UB=LB=1: no change but R still pulses.
  - Write to IO_ADDR updates HEX_reg with byte-enables applied, never RAM.
- Reset mid-access: immediate IDLE, no commit, R=0 next cycle.
- RAM: single port, synchronous read, infers block RAM.

Optional Feature:
- Macro SLC3_LED_REG_EN.
- Defined:
  - Adds output LED_reg [9:0], reset 10'h000.
  - Writes to IO_ADDR-1 (20'h0FFFE) store Data_from_CPU[9:0] into LED_reg, ignoring UB/LB, no RAM write.
  - Reads of 20'h0FFFE return {6'b0, LED_reg}.
- Not defined: no LED_reg port; 20'h0FFFE is ordinary aliased RAM.

Test Plan:
- Reset then write 16'hBEEF to 0x0005 (UB=LB=0, WAIT_STATES=2) -> R high exactly 3 cycles after acceptance for 1 cycle; read 0x0005 -> Data_to_CPU=16'hBEEF in ACK cycle.
- SW=10'h2A5, read IO_ADDR -> Data_to_CPU=16'h02A5; write 16'h1234 to IO_ADDR -> HEX_reg=16'h1234, RAM word 0x3FF unchanged.
- Byte-enable test:
  - Write 16'hAAAA to 0x0010.
  - Write 16'h5555 with LB=0, UB=1 -> read gives 16'hAA55.
  - Write 16'h1111 with UB=0, LB=1 -> read gives 16'h1155.
- Alias/wrap: write 16'h0777 to 0x00400 (ADDR_BITS=10) -> read 0x00000 returns 16'h0777.
- Abort: start write of 16'hFFFF to 0x0020 (prior 16'h0001), raise CE in WAIT -> no R pulse, read returns 16'h0001.
- Reset mid-write in WAIT -> R stays 0, HEX_reg=0, target word unchanged; next access after reset completes normally.
